// File: rtl/enigma_pkg.sv
// Shared constants, driver FSM state type and ASCII letter helpers for the Enigma message driver.
// ENIGMA_PASSTHRU_EN adds the PASS state used to forward non-letters unchanged.
package enigma_pkg;

    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam int unsigned ALPHA_LEN = 26;

`ifdef ENIGMA_PASSTHRU_EN
    typedef enum logic [2:0] {StIdle, StIssue, StWait, StStep, StPass} drv_state_e;
`else
    typedef enum logic [1:0] {StIdle, StIssue, StWait, StStep} drv_state_e;
`endif

    function automatic logic is_upper(input logic [7:0] b);
        return (b >= ASCII_UPPER_A) && (b < ASCII_UPPER_A + 8'(ALPHA_LEN));
    endfunction

    function automatic logic is_lower(input logic [7:0] b);
        return (b >= ASCII_LOWER_A) && (b < ASCII_LOWER_A + 8'(ALPHA_LEN));
    endfunction

    function automatic logic is_letter(input logic [7:0] b);
        return is_upper(b) || is_lower(b);
    endfunction

    // Case-folds a letter to its rotor index 0-25.
    function automatic logic [4:0] to_index(input logic [7:0] b);
        return 5'(is_upper(b) ? b - ASCII_UPPER_A : b - ASCII_LOWER_A);
    endfunction

endpackage

// File: rtl/enigma_byte_fifo.sv
// Synchronous byte FIFO with occupancy count. Caller must not push when full;
// pops on an empty FIFO are ignored.
module enigma_byte_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [7:0]             push_data,
    input  logic                   pop,
    output logic [7:0]             head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;

    assign full   = (count == DEPTH_CNT);
    assign empty  = (count == '0);
    assign do_pop = pop && !empty;
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/enigma_msg_driver.sv
// Host-to-cipher-core message driver: folds letters to rotor indices, runs the core handshake,
// steps the rotors and queues uppercase ciphertext. ENIGMA_PASSTHRU_EN forwards non-letters.
module enigma_msg_driver #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        core_valid,
    output logic [7:0]  core_din,
    input  logic        core_done,
    input  logic [7:0]  core_dout,
    output logic        core_en,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic [15:0] char_count,
    output logic        err
);

    import enigma_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] FIFO_DEPTH = CW'(DEPTH);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [7:0]    ALPHA_MAX  = 8'(ALPHA_LEN - 1);

    drv_state_e    state;
    logic [TW-1:0] timer;
    logic [4:0]    result;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_head;
    logic          push;
    logic [7:0]    push_data;
    logic          accept;

    assign in_ready  = reset_n && (state == StIdle) && (fifo_count < FIFO_DEPTH);
    assign accept    = in_valid && in_ready;
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? 8'h00 : fifo_head;

`ifdef ENIGMA_PASSTHRU_EN
    logic [7:0] pass_byte;
    assign push      = ((state == StStep) || (state == StPass)) && !fifo_full;
    assign push_data = (state == StPass) ? pass_byte : ASCII_UPPER_A + {3'b000, result};
`else
    assign push      = (state == StStep) && !fifo_full;
    assign push_data = ASCII_UPPER_A + {3'b000, result};
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= StIdle;
            core_valid <= 1'b0;
            core_din   <= 8'h00;
            core_en    <= 1'b0;
            char_count <= 16'h0000;
            err        <= 1'b0;
            timer      <= '0;
            result     <= '0;
`ifdef ENIGMA_PASSTHRU_EN
            pass_byte  <= 8'h00;
`endif
        end else begin
            core_valid <= 1'b0;
            core_en    <= 1'b0;
            case (state)
                StIdle: begin
                    if (accept) begin
                        if (is_letter(in_data)) begin
                            core_valid <= 1'b1;
                            core_din   <= {3'b000, to_index(in_data)};
                            state      <= StIssue;
                        end else begin
`ifdef ENIGMA_PASSTHRU_EN
                            pass_byte <= in_data;
                            state     <= StPass;
`endif
                        end
                    end
                end
                StIssue: begin
                    timer <= '0;
                    state <= StWait;
                end
                StWait: begin
                    // A done on the final budgeted cycle still wins over the timeout.
                    if (core_done) begin
                        if (core_dout <= ALPHA_MAX) begin
                            result  <= core_dout[4:0];
                            core_en <= 1'b1;
                            state   <= StStep;
                        end else begin
                            err   <= 1'b1;
                            state <= StIdle;
                        end
                    end else if (timer == TIMER_LAST) begin
                        err   <= 1'b1;
                        state <= StIdle;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                StStep: begin
                    char_count <= char_count + 16'd1;
                    state      <= StIdle;
                end
`ifdef ENIGMA_PASSTHRU_EN
                StPass: begin
                    state <= StIdle;
                end
`endif
                default: state <= StIdle;
            endcase
        end
    end

    enigma_byte_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push),
        .push_data(push_data),
        .pop      (out_ready),
        .head     (fifo_head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_enigma_msg_driver.sv
// Randomized self-checking bench for enigma_msg_driver with an inline cipher-core responder
// and a queue-based model of the expected output stream.
module tb_enigma_msg_driver;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        core_valid;
    logic [7:0]  core_din;
    logic        core_done = 1'b0;
    logic [7:0]  core_dout = 8'h00;
    logic        core_en;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready = 1'b0;
    logic [15:0] char_count;
    logic        err;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];
    int         exp_cnt = 0;
    logic       exp_err = 1'b0;
    int         exp_en = 0;
    int         en_seen = 0;
    int         valid_seen = 0;
    int         ready_mode = 1;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;

    enigma_msg_driver #(
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .core_valid(core_valid),
        .core_din  (core_din),
        .core_done (core_done),
        .core_dout (core_dout),
        .core_en   (core_en),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .char_count(char_count),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit ref_letter(input logic [7:0] b);
        return (b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A);
    endfunction

    function automatic logic [7:0] ref_idx(input logic [7:0] b);
        return (b <= 8'h5A) ? b - 8'h41 : b - 8'h61;
    endfunction

    function automatic logic [7:0] cipher(input logic [7:0] idx);
        return 8'((int'(idx) * 7 + 3) % 26);
    endfunction

    always @(negedge clk) begin
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        if (core_en === 1'b1) en_seen++;
        if (core_valid === 1'b1) valid_seen++;
    end

    // Output monitor: head must match the model queue and hold while stalled.
    always @(negedge clk) begin
        #2;
        if (reset_n) begin
            if (prev_hold) begin
                check_eq("out_hold_valid", 16'(out_valid), 16'd1);
                check_eq("out_hold_data", 16'(out_data), 16'(prev_data));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check_eq("out_extra", 16'(exp_q.size()), 16'd1);
                else check_eq("out_data", 16'(out_data), 16'(exp_q.pop_front()));
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
        end else begin
            prev_hold = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Offers one byte, plays the core for letters, and updates the model.
    task automatic send(input logic [7:0] b, input int d, input logic [7:0] resp,
                        input bit respond);
        int waitc;
        logic [7:0] idx;
        idx = ref_idx(b);
        in_data = b;
        in_valid = 1'b1;
        waitc = 0;
        while (in_ready !== 1'b1 && waitc < 400) begin
            @(negedge clk);
            waitc++;
        end
        if (in_ready !== 1'b1) begin
            check_eq("accept_wait", 16'(in_ready), 16'd1);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (ref_letter(b)) begin
            check_eq("core_valid", 16'(core_valid), 16'd1);
            check_eq("core_din", 16'(core_din), 16'(idx));
            check_eq("in_ready_issue", 16'(in_ready), 16'd0);
            @(negedge clk);
            check_eq("core_valid_pulse", 16'(core_valid), 16'd0);
            if (!respond) begin
                repeat (TIMEOUT - 1) @(negedge clk);
                check_eq("err_before_timeout", 16'(err), 16'(exp_err));
                @(negedge clk);
                exp_err = 1'b1;
                check_eq("err_timeout", 16'(err), 16'd1);
                check_eq("core_en_timeout", 16'(core_en), 16'd0);
            end else begin
                repeat (d) @(negedge clk);
                core_done = 1'b1;
                core_dout = resp;
                @(negedge clk);
                core_done = 1'b0;
                core_dout = 8'(~resp);
                if (resp <= 8'd25) begin
                    check_eq("core_en", 16'(core_en), 16'd1);
                    exp_q.push_back(8'h41 + resp);
                    exp_cnt++;
                    exp_en++;
                end else begin
                    exp_err = 1'b1;
                    check_eq("core_en_bad", 16'(core_en), 16'd0);
                    check_eq("err_bad", 16'(err), 16'd1);
                end
                @(negedge clk);
                check_eq("char_count", char_count, 16'(exp_cnt));
                check_eq("err", 16'(err), 16'(exp_err));
                check_eq("core_en_pulse", 16'(core_en), 16'd0);
            end
        end else begin
`ifdef ENIGMA_PASSTHRU_EN
            check_eq("pass_core_valid", 16'(core_valid), 16'd0);
            check_eq("pass_in_ready", 16'(in_ready), 16'd0);
            exp_q.push_back(b);
            @(negedge clk);
            check_eq("pass_char_count", char_count, 16'(exp_cnt));
`else
            check_eq("drop_core_valid", 16'(core_valid), 16'd0);
`endif
        end
    endtask

    initial begin
        logic [7:0] hello [5];
        logic [7:0] b;
        logic [7:0] resp;
        int es;
        int vs;
        int waitc;
        hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};

        idle(3);
        check_eq("rst_in_ready", 16'(in_ready), 16'd0);
        check_eq("rst_core_valid", 16'(core_valid), 16'd0);
        check_eq("rst_core_din", 16'(core_din), 16'd0);
        check_eq("rst_core_en", 16'(core_en), 16'd0);
        check_eq("rst_out_valid", 16'(out_valid), 16'd0);
        check_eq("rst_out_data", 16'(out_data), 16'd0);
        check_eq("rst_char_count", char_count, 16'd0);
        check_eq("rst_err", 16'(err), 16'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("in_ready_after_rst", 16'(in_ready), 16'd1);

        // 'a' enciphers to index 7 -> 'H'
        send(8'h61, 1, 8'd7, 1'b1);
        idle(4);
        check_eq("first_drained", 16'(exp_q.size()), 16'd0);

        // HELLO with downstream stalled: four buffered, fifth waits
        ready_mode = 0;
        idle(2);
        for (int i = 0; i < 4; i++) send(hello[i], $urandom_range(0, 3), cipher(ref_idx(hello[i])), 1'b1);
        check_eq("full_out_valid", 16'(out_valid), 16'd1);
        for (int i = 0; i < 3; i++) begin
            check_eq("full_in_ready", 16'(in_ready), 16'd0);
            @(negedge clk);
        end
        ready_mode = 1;
        send(hello[4], 2, cipher(ref_idx(hello[4])), 1'b1);
        idle(8);
        check_eq("hello_drained", 16'(exp_q.size()), 16'd0);

        // Space: forwarded or silently consumed depending on build
        vs = valid_seen;
        es = en_seen;
        send(8'h20, 0, 8'd0, 1'b1);
`ifndef ENIGMA_PASSTHRU_EN
        check_eq("space_in_ready", 16'(in_ready), 16'd1);
        check_eq("space_out_valid", 16'(out_valid), 16'd0);
`endif
        idle(4);
        check_eq("space_no_valid", 16'(valid_seen), 16'(vs));
        check_eq("space_no_en", 16'(en_seen), 16'(es));
        check_eq("space_drained", 16'(exp_q.size()), 16'd0);

        // Core never answers
        es = en_seen;
        send(8'h51, 0, 8'd0, 1'b0);
        check_eq("timeout_in_ready", 16'(in_ready), 16'd1);
        idle(3);
        check_eq("timeout_no_en", 16'(en_seen), 16'(es));
        check_eq("timeout_out_valid", 16'(out_valid), 16'd0);
        check_eq("timeout_char_count", char_count, 16'(exp_cnt));

        // Out-of-range core result
        send(8'h63, 2, 8'd30, 1'b1);
        idle(3);
        check_eq("bad_out_valid", 16'(out_valid), 16'd0);
        check_eq("bad_char_count", char_count, 16'(exp_cnt));

        // Reset while waiting on the core with two bytes queued
        ready_mode = 0;
        idle(2);
        send(8'h61, 1, 8'd3, 1'b1);
        send(8'h62, 0, 8'd4, 1'b1);
        check_eq("pre_rst_out_valid", 16'(out_valid), 16'd1);
        in_data = 8'h63;
        in_valid = 1'b1;
        check_eq("pre_rst_in_ready", 16'(in_ready), 16'd1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("wait_in_ready", 16'(in_ready), 16'd0);
        reset_n = 1'b0;
        es = en_seen;
        @(negedge clk);
        exp_q.delete();
        exp_cnt = 0;
        exp_err = 1'b0;
        check_eq("mid_rst_out_valid", 16'(out_valid), 16'd0);
        check_eq("mid_rst_char_count", char_count, 16'd0);
        check_eq("mid_rst_err", 16'(err), 16'd0);
        check_eq("mid_rst_in_ready", 16'(in_ready), 16'd0);
        reset_n = 1'b1;
        core_done = 1'b1;
        core_dout = 8'd5;
        @(negedge clk);
        core_done = 1'b0;
        check_eq("late_done_in_ready", 16'(in_ready), 16'd1);
        @(negedge clk);
        check_eq("late_done_core_en", 16'(core_en), 16'd0);
        check_eq("late_done_out_valid", 16'(out_valid), 16'd0);
        check_eq("late_done_char_count", char_count, 16'd0);
        check_eq("late_done_no_en", 16'(en_seen), 16'(es));

        // Randomized traffic with random downstream backpressure
        ready_mode = 2;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) < 7)
                b = ($urandom_range(0, 1) == 1 ? 8'h41 : 8'h61) + 8'($urandom_range(0, 25));
            else
                b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) resp = 8'($urandom_range(26, 255));
            else resp = 8'($urandom_range(0, 25));
            send(b, $urandom_range(0, 8), resp, 1'b1);
        end

        ready_mode = 1;
        send(8'h7A, 0, 8'd0, 1'b1);
        waitc = 0;
        while ((exp_q.size() != 0 || out_valid) && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        @(negedge clk);
        check_eq("final_drained", 16'(exp_q.size()), 16'd0);
        check_eq("final_out_valid", 16'(out_valid), 16'd0);
        check_eq("final_en_count", 16'(en_seen), 16'(exp_en));
        check_eq("final_char_count", char_count, 16'(exp_cnt));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/enigma_msg_driver.md
# enigma_msg_driver

Initiator-side message driver for the Enigma cipher core. Accepts an upstream ASCII byte stream, folds letters to rotor indices 0–25, and issues one character at a time into the core's valid/din → done/dout handshake. It pulses the core's rotor-step enable after every enciphered letter and returns uppercase ASCII ciphertext through a small output FIFO. It sits between the host byte interface and the cipher core's first-rotor input and last-rotor output.

## Interface
- DEPTH, 4, output FIFO entries (power of two, ≥2)
- TIMEOUT, 64, max cycles to wait for core done before abort
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  upstream byte valid
- in_data  in  8  upstream ASCII byte
- in_ready  out  1  driver accepts in_data this cycle
- core_valid  out  1  one-cycle request to cipher core
- core_din  out  8  rotor index 0–25 presented with core_valid
- core_done  in  1  core result strobe
- core_dout  in  8  core result index
- core_en  out  1  one-cycle rotor-step pulse
- out_valid  out  1  FIFO non-empty
- out_data  out  8  FIFO head, ASCII
- out_ready  in  1  downstream pops head when out_valid & out_ready
- char_count  out  16  letters successfully enciphered, wraps at 0xFFFF→0
- err  out  1  sticky: timeout or core_dout > 25

## Operation
- States: IDLE, ISSUE, WAIT, STEP, PASS.
- IDLE: in_ready = (fifo count < DEPTH). On in_valid & in_ready, latch byte.
  - 'A'–'Z' → idx = byte−0x41; 'a'–'z' → idx = byte−0x61; go ISSUE.
  - Non-letter: see Configuration.
- ISSUE: core_valid=1, core_din=idx for exactly one cycle; clear timeout counter; go WAIT.
- WAIT: increment timeout counter each cycle.
  - core_done=1 and core_dout ≤ 25: capture it, go STEP.
  - core_done=1 and core_dout > 25: set err, drop the byte, go IDLE (no step).
  - Counter reaches TIMEOUT without done: set err, drop the byte, go IDLE (no step).
- STEP: core_en=1 for one cycle; write 0x41+captured idx to FIFO; char_count+1; go IDLE.
- PASS: write the latched byte to FIFO unchanged; no core_en; char_count unchanged; go IDLE.
- core_done outside WAIT is ignored.
- FIFO cannot overflow: accept requires count < DEPTH, and at most one byte is in flight.
- Simultaneous FIFO push and pop: count unchanged, order preserved.
- err clears only on reset.

## Timing
- Reset values: in_ready 0 during reset, then 1 from the first cycle after reset release when FIFO empty.
- All other outputs reset to 0: core_valid, core_din, core_en, out_valid, out_data, char_count, err. FIFO empties; state returns to IDLE.
- Reset mid-operation discards the in-flight byte and all FIFO contents.
- No core_en is issued during or after reset for the discarded byte.
- Letter latency:
  - accept edge at cycle 0;
  - core_valid in cycle 1;
  - done earliest in cycle 2, in cycle k generally;
  - core_en and FIFO write in cycle k+1;
  - out_valid from cycle k+2.
- Passthrough latency: accept at cycle 0, PASS in cycle 1, out_valid from cycle 2.
- in_ready is 0 in every state except IDLE; throughput is at most one letter per 4 cycles.
- out_data is stable while out_valid & !out_ready.

## Configuration
- ENIGMA_PASSTHRU_EN defined: a non-letter accepted in IDLE goes to PASS and appears unchanged in the output stream (spaces, punctuation preserved).
- ENIGMA_PASSTHRU_EN undefined: a non-letter is consumed (handshake completes) and discarded. State stays IDLE, nothing is written, and the PASS state is not built.

## Structure
- Shared package enigma_pkg:
  - ASCII_UPPER_A (8'h41), ASCII_LOWER_A (8'h61), ALPHA_LEN (26)
  - state enum for this block
  - helper is-letter / to-index function
- One sub-module: enigma_byte_fifo, a synchronous FIFO parameterized by DEPTH with push, pop, count, full, and empty.

## Test plan
- Reset, then in 'a' (0x61); core model returns 7 two cycles after core_valid → core_din=0, one core_en pulse, out_data 'H' (0x48), char_count=1.
- Stream "HELLO" with out_ready=0 and DEPTH=4 → four outputs buffered, in_ready low while FIFO full. Raise out_ready → fifth byte accepted, order preserved.
- Core never asserts done → err set after 64 WAIT cycles, no core_en, no FIFO write, back to IDLE accepting.
- Core returns 30 → err set, byte dropped, char_count unchanged.
- In ' ' (0x20): with ENIGMA_PASSTHRU_EN, out 0x20 and no core_valid/core_en; without it, no output and in_ready stays 1.
- reset_n low in WAIT with 2 bytes in FIFO → next cycle out_valid=0, char_count=0, err=0; late core_done ignored.
